// File: rtl/jk_counter_bank.sv
// jk_counter_bank: WIDTH-bit JK flag bank / modulo up-down counter / loadable register.
// Define JKCB_STICKY_OVF_EN to get a sticky ovf flag set on wraps, cleared by load or clr.
module jk_counter_bank #(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MODULUS   = 256,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [1:0] M_JK   = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    // Top of the count range; wraps to all ones when MODULUS = 2^WIDTH.
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        unique case (mode)
            M_JK: begin
                q_d = (j & ~q_q) | (~k & q_q);
            end
            M_UP: begin
                if (q_q >= MAXV) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + ONE;
                end
            end
            M_DOWN: begin
                // Out-of-range values saturate into range without a wrap.
                if (q_q == '0) begin
                    q_d    = MAXV;
                    wrap_d = 1'b1;
                end else if (q_q > MAXV) begin
                    q_d = MAXV;
                end else begin
                    q_d = q_q - ONE;
                end
            end
            M_LOAD: begin
                q_d = d;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q    <= RST;
            wrap_q <= 1'b0;
        end else if (en) begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef JKCB_STICKY_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | wrap_d;
        if (mode == M_LOAD) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign q    = q_q;
    assign wrap = wrap_q;
    assign tc   = ((mode == M_UP) && (q_q >= MAXV)) ||
                  ((mode == M_DOWN) && (q_q == '0));

endmodule

// File: tb/tb_jk_counter_bank.sv
// Self-checking bench for jk_counter_bank at WIDTH=4, MODULUS=10, RESET_VAL=0.
// Directed scenarios plus randomized traffic against an integer reference model.
module tb_jk_counter_bank;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk, clr, en;
    logic [1:0]   mode;
    logic [W-1:0] j, k, d, q;
    logic         tc, wrap, ovf;

    int errors = 0;
    int checks = 0;

    int mq, mw, mo;

    jk_counter_bank #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) dut (
        .clk(clk), .clr(clr), .en(en), .mode(mode),
        .j(j), .k(k), .d(d),
        .q(q), .tc(tc), .wrap(wrap), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sticky_on();
`ifdef JKCB_STICKY_OVF_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    function automatic int model_tc(input int md);
        return ((md == 1 && mq >= M - 1) || (md == 2 && mq == 0)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        mq = 0; mw = 0; mo = 0;
    endtask

    task automatic model_edge(input int e, input int md, input int jj, input int kk, input int dd);
        int nq;
        int w;
        if (e == 0) return;
        nq = mq;
        w  = 0;
        case (md)
            0: begin
                for (int b = 0; b < W; b++) begin
                    int jb, kb, qb;
                    jb = (jj >> b) & 1;
                    kb = (kk >> b) & 1;
                    qb = (mq >> b) & 1;
                    if (jb == 1 && kb == 0) qb = 1;
                    else if (jb == 0 && kb == 1) qb = 0;
                    else if (jb == 1 && kb == 1) qb = 1 - qb;
                    if (qb == 1) nq = nq | (1 << b);
                    else nq = nq & ~(1 << b);
                end
            end
            1: begin
                if (mq >= M - 1) begin nq = 0; w = 1; end
                else nq = mq + 1;
            end
            2: begin
                if (mq == 0) begin nq = M - 1; w = 1; end
                else if (mq > M - 1) nq = M - 1;
                else nq = mq - 1;
            end
            default: nq = dd;
        endcase
        mq = nq;
        mw = w;
        if (sticky_on() == 1) begin
            if (md == 3) mo = 0;
            else if (w == 1) mo = 1;
        end
    endtask

    task automatic cyc(input logic e, input logic [1:0] m,
                       input logic [W-1:0] jj, input logic [W-1:0] kk,
                       input logic [W-1:0] dd);
        en = e; mode = m; j = jj; k = kk; d = dd;
        @(posedge clk);
        model_edge(int'(e), int'(m), int'(jj), int'(kk), int'(dd));
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0;
        #2;
        model_reset();
        checks++;
        if (q !== 4'd0 || wrap !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_init q=%0d wrap=%0b ovf=%0b required 0/0/0", q, wrap, ovf);
        end
        clr = 1'b0;
        cyc(1'b1, 2'b11, '0, '0, 4'd7);
        checks++;
        if (q !== 4'd7) begin
            errors++;
            $display("FAIL reset_preload q=%0d required 7", q);
        end
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        checks++;
        if (q !== 4'd0 || wrap !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_async q=%0d wrap=%0b ovf=%0b required 0/0/0", q, wrap, ovf);
        end
        en = 1'b1; mode = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold q=%0d required 0", q);
        end
        clr = 1'b0;
    endtask

    task automatic test_jk();
        logic [W-1:0] js [4];
        logic [W-1:0] ks [4];
        logic [W-1:0] ex [4];
        js = '{4'b1010, 4'b0000, 4'b1111, 4'b0000};
        ks = '{4'b0000, 4'b0010, 4'b1111, 4'b0000};
        ex = '{4'b1010, 4'b1000, 4'b0111, 4'b0111};
        cyc(1'b1, 2'b11, '0, '0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'b00, js[i], ks[i], '0);
            checks++;
            if (q !== ex[i] || wrap !== 1'b0 || tc !== 1'b0) begin
                errors++;
                $display("FAIL jk_step%0d q=%b wrap=%0b tc=%0b required %b/0/0", i, q, wrap, tc, ex[i]);
            end
        end
    endtask

    task automatic test_count_up();
        cyc(1'b1, 2'b11, '0, '0, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            en = 1'b1; mode = 2'b01;
            #1;
            checks++;
            if (tc !== ((i == 10) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL up_tc%0d tc=%0b q=%0d", i, tc, q);
            end
            cyc(1'b1, 2'b01, '0, '0, '0);
            checks++;
            if (q !== W'(i % 10) || wrap !== ((i == 10) ? 1'b1 : 1'b0) ||
                ovf !== ((i >= 10 && sticky_on() == 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL up_step%0d q=%0d wrap=%0b ovf=%0b required q=%0d", i, q, wrap, ovf, i % 10);
            end
        end
    endtask

    task automatic test_count_down();
        cyc(1'b1, 2'b11, '0, '0, 4'd13);
        cyc(1'b1, 2'b10, '0, '0, '0);
        checks++;
        if (q !== 4'd9 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_entry q=%0d wrap=%0b required 9/0", q, wrap);
        end
        for (int v = 8; v >= 0; v--) begin
            cyc(1'b1, 2'b10, '0, '0, '0);
            checks++;
            if (q !== W'(v) || wrap !== 1'b0) begin
                errors++;
                $display("FAIL down_step q=%0d wrap=%0b required %0d/0", q, wrap, v);
            end
        end
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL down_tc tc=%0b required 1", tc);
        end
        cyc(1'b1, 2'b10, '0, '0, '0);
        checks++;
        if (q !== 4'd9 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap q=%0d wrap=%0b required 9/1", q, wrap);
        end
        cyc(1'b1, 2'b11, '0, '0, 4'd13);
        cyc(1'b1, 2'b01, '0, '0, '0);
        checks++;
        if (q !== 4'd0 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL up_from_oor q=%0d wrap=%0b required 0/1", q, wrap);
        end
    endtask

    task automatic test_en_gate();
        cyc(1'b1, 2'b11, '0, '0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b01, '0, '0, '0);
            checks++;
            if (q !== 4'd5 || wrap !== 1'b0 || tc !== 1'b0) begin
                errors++;
                $display("FAIL en_hold5 q=%0d wrap=%0b tc=%0b required 5/0/0", q, wrap, tc);
            end
        end
        cyc(1'b1, 2'b11, '0, '0, 4'd9);
        cyc(1'b0, 2'b01, '0, '0, '0);
        checks++;
        if (q !== 4'd9 || tc !== 1'b1) begin
            errors++;
            $display("FAIL en_tc q=%0d tc=%0b required 9/1", q, tc);
        end
        cyc(1'b1, 2'b01, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b10, '0, '0, 4'd3);
            checks++;
            if (q !== 4'd0 || wrap !== 1'b1) begin
                errors++;
                $display("FAIL en_holdwrap q=%0d wrap=%0b required 0/1", q, wrap);
            end
        end
    endtask

    task automatic test_sticky();
        if (sticky_on() == 0) begin
            cyc(1'b1, 2'b10, '0, '0, '0);
            checks++;
            if (ovf !== 1'b0) begin
                errors++;
                $display("FAIL ovf_tied ovf=%0b required 0", ovf);
            end
            return;
        end
        cyc(1'b1, 2'b11, '0, '0, 4'd9);
        cyc(1'b1, 2'b01, '0, '0, '0);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set ovf=%0b required 1", ovf);
        end
        repeat (5) cyc(1'b1, 2'b01, '0, '0, '0);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky ovf=%0b required 1", ovf);
        end
        cyc(1'b1, 2'b11, '0, '0, 4'd3);
        checks++;
        if (q !== 4'd3 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_load q=%0d ovf=%0b required 3/0", q, ovf);
        end
        cyc(1'b1, 2'b11, '0, '0, 4'd0);
        cyc(1'b1, 2'b10, '0, '0, '0);
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        checks++;
        if (ovf !== 1'b0 || q !== 4'd0) begin
            errors++;
            $display("FAIL ovf_clr ovf=%0b q=%0d required 0/0", ovf, q);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic         e;
            logic [1:0]   m;
            logic [W-1:0] rj, rk, rd;
            e  = ($urandom_range(0, 4) != 0);
            m  = 2'($urandom_range(0, 3));
            rj = W'($urandom);
            rk = W'($urandom);
            rd = W'($urandom);
            en = e; mode = m;
            #1;
            checks++;
            if (tc !== 1'(model_tc(int'(m)))) begin
                errors++;
                $display("FAIL rand_tc n=%0d tc=%0b required %0d", n, tc, model_tc(int'(m)));
            end
            cyc(e, m, rj, rk, rd);
            checks++;
            if (q !== W'(mq) || wrap !== 1'(mw) || ovf !== 1'(mo)) begin
                errors++;
                $display("FAIL rand_state n=%0d q=%0d wrap=%0b ovf=%0b required %0d/%0d/%0d",
                         n, q, wrap, ovf, mq, mw, mo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jk();
        test_count_up();
        test_count_down();
        test_en_gate();
        test_sticky();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
